// File: rtl/serial_tc_pkg.sv
// serial_tc_pkg: mode encodings, output sequencer states and the negate decision
// shared by the serial two's-complement unit.
package serial_tc_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_BUSY = 1'b1
  } out_state_t;

  // The reserved encoding 2'b11 falls through to pass-through behaviour.
  function automatic logic calc_negate(input logic [1:0] op, input logic msb);
    logic neg;
    case (op)
      MODE_PASS: neg = 1'b0;
      MODE_NEG:  neg = 1'b1;
      MODE_ABS:  neg = msb;
      default:   neg = 1'b0;
    endcase
    return neg;
  endfunction

endpackage

// File: rtl/serial_tc_neg.sv
// serial_tc_neg: bit-serial two's-complement cell. Bits pass unchanged up to and
// including the first 1 of the word, and are inverted after it when neg is set.
module serial_tc_neg (
  input  logic t_clk,
  input  logic t_rst_n,
  input  logic start,
  input  logic en,
  input  logic d,
  input  logic neg,
  output logic q
);

  logic seen_one;
  logic seen_eff;

  // The LSB beat ignores history left over from the previous word.
  assign seen_eff = seen_one & ~start;

  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      seen_one <= 1'b0;
    end else if (en) begin
      seen_one <= seen_eff | d;
    end
  end

  assign q = d ^ (neg & seen_eff);

endmodule

// File: rtl/serial_tc_unit.sv
// serial_tc_unit: LSB-first serial PASS / NEGATE / ABS unit with a double-buffered word.
// Define SERIAL_TC_SAT_EN to saturate a negated most-negative word to max positive.
module serial_tc_unit #(
  parameter int W = 8
) (
  input  logic       t_clk,
  input  logic       t_rst_n,
  input  logic       i_bit,
  input  logic       i_valid,
  input  logic       i_sof,
  input  logic [1:0] mode,
  output logic       y_bit,
  output logic       y_valid,
  output logic       y_sof,
  output logic       y_ovf,
  output logic       err
);

  import serial_tc_pkg::*;

  localparam int            CW   = $clog2(W);
  localparam int            DW   = W - 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  // Capture side
  logic [CW-1:0] cap_cnt;
  logic [DW-1:0] cap_data;
  logic [1:0]    cap_mode;
  logic          accept;
  logic          frame_err;
  logic          transfer;
  logic [W-1:0]  word_full;
  logic          word_neg;
  logic          word_min;

  // Output side
  out_state_t    state;
  out_state_t    state_next;
  logic [W-1:0]  out_shift;
  logic [CW-1:0] out_cnt;
  logic          out_neg;
  logic          out_ovf;
  logic          busy;
  logic          out_first;
  logic          out_last;
  logic          neg_q;

  // A counter of zero means "waiting for a start of frame"; only i_sof may begin a word.
  assign accept    = i_valid & (i_sof | (cap_cnt != '0));
  assign frame_err = i_valid & i_sof & (cap_cnt != '0);
  assign transfer  = i_valid & ~i_sof & (cap_cnt == LAST);

  // The MSB is taken straight from the input so the word is complete on its own beat.
  assign word_full = {i_bit, cap_data};
  assign word_neg  = calc_negate(cap_mode, i_bit);
  assign word_min  = i_bit & (cap_data == '0);

  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      cap_cnt  <= '0;
      cap_data <= '0;
      cap_mode <= MODE_PASS;
      err      <= 1'b0;
    end else begin
      err <= frame_err;
      if (accept) begin
        cap_data <= DW'({i_bit, cap_data} >> 1);
      end
      if (i_valid && i_sof) begin
        cap_cnt  <= CW'(1);
        cap_mode <= mode;
      end else if (transfer) begin
        cap_cnt <= '0;
      end else if (accept) begin
        cap_cnt <= cap_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      state <= OUT_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A transfer on the last output beat keeps the sequencer busy, giving gapless words.
  always_comb begin
    state_next = state;
    unique case (state)
      OUT_IDLE: if (transfer) state_next = OUT_BUSY;
      OUT_BUSY: if (out_last && !transfer) state_next = OUT_IDLE;
      default:  state_next = OUT_IDLE;
    endcase
  end

  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      out_shift <= '0;
      out_cnt   <= '0;
      out_neg   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (transfer) begin
      out_shift <= word_full;
      out_cnt   <= '0;
      out_neg   <= word_neg;
      out_ovf   <= word_neg & word_min;
    end else if (busy) begin
      out_shift <= out_shift >> 1;
      out_cnt   <= out_last ? '0 : out_cnt + CW'(1);
    end
  end

  assign busy      = (state == OUT_BUSY);
  assign out_first = busy & (out_cnt == '0);
  assign out_last  = busy & (out_cnt == LAST);

  serial_tc_neg u_neg (
    .t_clk   (t_clk),
    .t_rst_n (t_rst_n),
    .start   (out_first),
    .en      (busy),
    .d       (out_shift[0]),
    .neg     (out_neg),
    .q       (neg_q)
  );

  always_comb begin
    y_valid = busy;
    y_sof   = out_first;
    y_ovf   = out_last & out_ovf;
`ifdef SERIAL_TC_SAT_EN
    y_bit   = busy & (out_ovf ? ~out_last : neg_q);
`else
    y_bit   = busy & neg_q;
`endif
  end

endmodule

// File: tb/tb_serial_tc_unit.sv
// tb_serial_tc_unit: directed bench with an arithmetic reference model and a
// per-cycle output checker for serial_tc_unit (W=8, honours SERIAL_TC_SAT_EN).
module tb_serial_tc_unit;

  localparam int W = 8;
`ifdef SERIAL_TC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int IDLE_BUDGET = 200;

  typedef struct {
    logic [W-1:0] word;
    logic         ovf;
  } exp_t;

  logic       t_clk = 1'b0;
  logic       t_rst_n;
  logic       i_bit;
  logic       i_valid;
  logic       i_sof;
  logic [1:0] mode;
  logic       y_bit;
  logic       y_valid;
  logic       y_sof;
  logic       y_ovf;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t         exp_q[$];
  logic [W-1:0] got_q[$];
  exp_t         cur_exp;
  bit           have_exp = 1'b0;
  int           beat_idx = 0;
  logic [W-1:0] got_word = '0;
  logic [W-1:0] last_word = '0;
  logic         last_ovf = 1'b0;
  int           cur_run = 0;
  int           max_run = 0;
  int           sof_cyc = 0;
  int           msb_cyc = 0;
  int           err_pulses = 0;
  int           err_cycles = 0;
  logic         err_prev = 1'b0;

  serial_tc_unit #(.W(W)) dut (
    .t_clk   (t_clk),
    .t_rst_n (t_rst_n),
    .i_bit   (i_bit),
    .i_valid (i_valid),
    .i_sof   (i_sof),
    .mode    (mode),
    .y_bit   (y_bit),
    .y_valid (y_valid),
    .y_sof   (y_sof),
    .y_ovf   (y_ovf),
    .err     (err)
  );

  always #5 t_clk = ~t_clk;

  always @(posedge t_clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: interpret the word as signed, negate arithmetically, then clamp or wrap.
  function automatic exp_t model(input logic [W-1:0] x, input logic [1:0] m);
    exp_t e;
    int   s;
    bit   negate;
    s      = x[W-1] ? int'(x) - (1 << W) : int'(x);
    negate = (m == 2'b01) || ((m == 2'b10) && (s < 0));
    e.word = x;
    e.ovf  = 1'b0;
    if (negate) begin
      if (-s > (1 << (W - 1)) - 1) begin
        e.ovf  = 1'b1;
        e.word = SAT ? W'((1 << (W - 1)) - 1) : x;
      end else begin
        e.word = W'(-s);
      end
    end
    return e;
  endfunction

  // Per-cycle compare against the model queue.
  always @(negedge t_clk) begin
    if (!t_rst_n) begin
      exp_q.delete();
      beat_idx = 0;
      cur_run  = 0;
      have_exp = 1'b0;
    end else if (y_valid) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (beat_idx == 0) begin
        check_output("output_expected", 32'(exp_q.size() != 0), 32'd1);
        have_exp = (exp_q.size() != 0);
        if (have_exp) cur_exp = exp_q.pop_front();
        sof_cyc = cyc;
      end
      check_output("y_sof", 32'(y_sof), 32'(beat_idx == 0));
      check_output("y_ovf", 32'(y_ovf), 32'(have_exp && (beat_idx == W - 1) && cur_exp.ovf));
      got_word[beat_idx] = y_bit;
      if (beat_idx == W - 1) last_ovf = y_ovf;
      beat_idx++;
      if (beat_idx == W) begin
        if (have_exp) check_output("word", 32'(got_word), 32'(cur_exp.word));
        got_q.push_back(got_word);
        last_word = got_word;
        beat_idx  = 0;
      end
    end else begin
      cur_run = 0;
      check_output("no_gap_mid_word", 32'(beat_idx), 32'd0);
      check_output("idle_flags", {30'd0, y_sof, y_ovf}, 32'd0);
    end
  end

  always @(negedge t_clk) begin
    if (t_rst_n) begin
      if (err) err_cycles++;
      if (err && !err_prev) err_pulses++;
      err_prev = err;
    end else begin
      err_prev = 1'b0;
    end
  end

  task automatic apply_stimulus(input logic [W-1:0] word, input logic [1:0] m, input bit gap);
    for (int i = 0; i < W; i++) begin
      i_valid = 1'b1;
      i_bit   = word[i];
      i_sof   = (i == 0);
      mode    = (i == 0) ? m : m + 2'd1;
      if (i == W - 1) begin
        exp_q.push_back(model(word, m));
        msb_cyc = cyc;
      end
      @(posedge t_clk); #1;
      if (gap) begin
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_bit   = ~i_bit;
        @(posedge t_clk); #1;
      end
    end
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic drive_loose_bits(input int n, input bit first_sof);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_sof   = first_sof && (i == 0);
      i_bit   = i[0];
      mode    = 2'b01;
      @(posedge t_clk); #1;
    end
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || beat_idx != 0) && n < IDLE_BUDGET) begin
      @(posedge t_clk);
      n++;
    end
    #1;
    check_output("idle_within_budget", 32'(n < IDLE_BUDGET), 32'd1);
    repeat (2) @(posedge t_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0, c0, n0;
    t_rst_n = 1'b0;
    i_bit   = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    mode    = 2'b00;
    repeat (3) @(posedge t_clk);
    #1;
    check_output("reset_y_valid", 32'(y_valid), 32'd0);
    check_output("reset_y_bit",   32'(y_bit),   32'd0);
    check_output("reset_y_sof",   32'(y_sof),   32'd0);
    check_output("reset_y_ovf",   32'(y_ovf),   32'd0);
    check_output("reset_err",     32'(err),     32'd0);
    @(posedge t_clk); #1;
    t_rst_n = 1'b1;
    @(posedge t_clk); #1;

    $display("[TB] negate 0x05 after pre-sof junk");
    drive_loose_bits(3, 1'b0);
    apply_stimulus(8'h05, 2'b01, 1'b0);
    wait_idle();
    check_output("neg05_word", 32'(last_word), 32'h0000_00FB);
    check_output("neg05_ovf", 32'(last_ovf), 32'd0);
    check_output("neg05_latency", 32'(sof_cyc), 32'(msb_cyc + 1));
    check_output("neg05_count", 32'(got_q.size()), 32'd1);

    $display("[TB] abs 0xF6 then abs 0x0A back to back");
    max_run = 0;
    apply_stimulus(8'hF6, 2'b10, 1'b0);
    apply_stimulus(8'h0A, 2'b10, 1'b0);
    wait_idle();
    check_output("abs_run", 32'(max_run), 32'd16);
    check_output("abs_first", 32'(got_q[got_q.size() - 2]), 32'h0000_000A);
    check_output("abs_second", 32'(got_q[got_q.size() - 1]), 32'h0000_000A);

    $display("[TB] negate most negative, then reserved mode");
    apply_stimulus(8'h80, 2'b01, 1'b0);
    wait_idle();
    check_output("neg80_word", 32'(last_word), SAT ? 32'h0000_007F : 32'h0000_0080);
    check_output("neg80_ovf", 32'(last_ovf), 32'd1);
    apply_stimulus(8'h80, 2'b11, 1'b0);
    wait_idle();
    check_output("rsv80_word", 32'(last_word), 32'h0000_0080);
    check_output("rsv80_ovf", 32'(last_ovf), 32'd0);

    $display("[TB] pass 0x3C with i_valid toggling");
    max_run = 0;
    apply_stimulus(8'h3C, 2'b00, 1'b1);
    wait_idle();
    check_output("pass3c_word", 32'(last_word), 32'h0000_003C);
    check_output("pass3c_run", 32'(max_run), 32'd8);

    $display("[TB] framing error after 3 bits, then negate 0x01");
    e0 = err_pulses;
    c0 = err_cycles;
    n0 = got_q.size();
    drive_loose_bits(3, 1'b1);
    apply_stimulus(8'h01, 2'b01, 1'b0);
    wait_idle();
    check_output("frame_err_pulses", 32'(err_pulses - e0), 32'd1);
    check_output("frame_err_width", 32'(err_cycles - c0), 32'd1);
    check_output("frame_words", 32'(got_q.size() - n0), 32'd1);
    check_output("frame_word", 32'(last_word), 32'h0000_00FF);

    $display("[TB] reset during output beat 4");
    apply_stimulus(8'h5A, 2'b00, 1'b0);
    repeat (3) @(posedge t_clk);
    #2;
    t_rst_n = 1'b0;
    #1;
    check_output("rst_mid_y_valid", 32'(y_valid), 32'd0);
    check_output("rst_mid_y_bit",   32'(y_bit),   32'd0);
    n0 = got_q.size();
    repeat (2) @(posedge t_clk);
    #1;
    t_rst_n = 1'b1;
    drive_loose_bits(4, 1'b0);
    repeat (20) @(posedge t_clk);
    #1;
    check_output("rst_no_output", 32'(got_q.size()), 32'(n0));
    check_output("rst_idle_valid", 32'(y_valid), 32'd0);
    apply_stimulus(8'h2A, 2'b01, 1'b0);
    wait_idle();
    check_output("rst_new_word", 32'(last_word), 32'h0000_00D6);
    check_output("rst_new_count", 32'(got_q.size()), 32'(n0 + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
